time_set_ctrl: RTL

Time-keeping and set-mode controller for the four-digit HH:MM clock. It keeps hours and minutes in BCD and debounces the mode and increment buttons. It runs the adjust/stopwatch mode state machine and generates the digit scan. It sits directly upstream of the seven-segment display stage and drives that stage's `sec_en`, `control_dig`, `sel` and `key` inputs.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/time_set_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and BCD limits for the HH:MM clock: mode codes, digit
// maxima and the blank-digit key value.
package clock_pkg;

   typedef enum logic [2:0] {
      MODE_NORMAL = 3'd0,
      MODE_MU     = 3'd1,
      MODE_MT     = 3'd2,
      MODE_HU     = 3'd3,
      MODE_HT     = 3'd4,
      MODE_SW     = 3'd5
   } mode_e;

   localparam logic [3:0] HT_MAX       = 4'd2;
   localparam logic [3:0] HU_MAX       = 4'd9;
   localparam logic [3:0] HU_MAX_AT_20 = 4'd3;
   localparam logic [3:0] MT_MAX       = 4'd5;
   localparam logic [3:0] MU_MAX       = 4'd9;
   localparam logic [5:0] SEC_MAX      = 6'd59;
   localparam logic [3:0] KEY_BLANK    = 4'hF;

   function automatic logic [3:0] bcd_inc_wrap(input logic [3:0] d, input logic [3:0] max);
      return (d >= max) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low button conditioner: 2-FF synchroniser, hold-time debounce and a
// one-cycle pulse on each accepted press (stable 1->0).
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 270_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         stable <= 1'b1;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         press <= 1'b0;
         // Any return to the stable level restarts the hold count.
         if (sync2 != stable) begin
            if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
               stable <= sync2;
               cnt    <= '0;
               press  <= ~sync2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// HH:MM timekeeping, set-mode FSM, button conditioning and digit scan.
// Define TIME_SET_STOPWATCH_EN to build the STOPWATCH mode and its counter.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned SEC_DIV      = 27_000_000,
   parameter int unsigned SCAN_DIV     = 27_000,
   parameter int unsigned DEBOUNCE_CYC = 270_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode_n,
   input  logic       btn_inc_n,
   output logic       sec_en,
   output logic [2:0] control_dig,
   output logic [1:0] sel,
   output logic [3:0] key
);

   localparam int unsigned PRE_W  = (SEC_DIV  > 1) ? $clog2(SEC_DIV)  : 1;
   localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic              mode_press;
   logic              inc_raw;
   logic              inc_press;
   mode_e             state;
   mode_e             state_nxt;
   logic [PRE_W-1:0]  pre;
   logic              tick;
   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        sel_nxt;
   logic [3:0]        disp;
   logic [5:0]        sec_cnt;
   logic [3:0]        ht, hu, mt, mu;
   logic              counting;
   logic              leave_mu;
   logic              min_carry;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_mode_n),
      .press (mode_press)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_inc_n),
      .press (inc_raw)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    pre <= '0;
      else if (tick) pre <= '0;
      else           pre <= pre + 1'b1;
   end

   always_comb begin
      tick   = (pre == PRE_W'(SEC_DIV - 1));
      sec_en = (pre < PRE_W'(SEC_DIV / 2));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MODE_NORMAL;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (mode_press) begin
         case (state)
            MODE_NORMAL: state_nxt = MODE_HT;
            MODE_HT:     state_nxt = MODE_HU;
            MODE_HU:     state_nxt = MODE_MT;
            MODE_MT:     state_nxt = MODE_MU;
`ifdef TIME_SET_STOPWATCH_EN
            MODE_MU:     state_nxt = MODE_SW;
`else
            MODE_MU:     state_nxt = MODE_NORMAL;
`endif
            MODE_SW:     state_nxt = MODE_NORMAL;
            default:     state_nxt = MODE_NORMAL;
         endcase
      end
   end

   always_comb begin
      control_dig = state;
   end

   // Events are qualified with the pre-transition state; mode beats increment.
   always_comb begin
      inc_press = inc_raw & ~mode_press;
      counting  = (state == MODE_NORMAL) || (state == MODE_SW);
      leave_mu  = (state == MODE_MU) && mode_press;
      min_carry = tick && counting && (sec_cnt == SEC_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_cnt <= '0;
      end else if (leave_mu) begin
         sec_cnt <= '0;
      end else if (tick && counting) begin
         sec_cnt <= (sec_cnt == SEC_MAX) ? 6'd0 : sec_cnt + 6'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ht <= '0;
         hu <= '0;
         mt <= '0;
         mu <= '0;
      end else if (min_carry) begin
         mu <= bcd_inc_wrap(mu, MU_MAX);
         if (mu == MU_MAX) begin
            mt <= bcd_inc_wrap(mt, MT_MAX);
            if (mt == MT_MAX) begin
               if (ht == HT_MAX && hu == HU_MAX_AT_20) begin
                  ht <= '0;
                  hu <= '0;
               end else if (hu == HU_MAX) begin
                  hu <= '0;
                  ht <= ht + 4'd1;
               end else begin
                  hu <= hu + 4'd1;
               end
            end
         end
      end else if (inc_press) begin
         case (state)
            MODE_HT: begin
               ht <= bcd_inc_wrap(ht, HT_MAX);
               if (ht == HT_MAX - 4'd1 && hu > HU_MAX_AT_20) hu <= HU_MAX_AT_20;
            end
            MODE_HU: hu <= bcd_inc_wrap(hu, (ht == HT_MAX) ? HU_MAX_AT_20 : HU_MAX);
            MODE_MT: mt <= bcd_inc_wrap(mt, MT_MAX);
            MODE_MU: mu <= bcd_inc_wrap(mu, MU_MAX);
            default: ;
         endcase
      end
   end

`ifdef TIME_SET_STOPWATCH_EN
   logic       sw_run;
   logic [3:0] sw_tens;
   logic [3:0] sw_units;

   // Count uses the run flag as it was before any toggle in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_run   <= 1'b0;
         sw_tens  <= '0;
         sw_units <= '0;
      end else if (leave_mu) begin
         sw_run   <= 1'b0;
         sw_tens  <= '0;
         sw_units <= '0;
      end else if (state == MODE_SW) begin
         if (tick && sw_run) begin
            sw_units <= bcd_inc_wrap(sw_units, MU_MAX);
            if (sw_units == MU_MAX) sw_tens <= bcd_inc_wrap(sw_tens, MT_MAX);
         end
         if (inc_press) sw_run <= ~sw_run;
      end
   end
`endif

   always_comb begin
      sel_nxt = sel + 2'd1;
      disp    = '0;
      case (sel_nxt)
         2'd0: disp = ht;
         2'd1: disp = hu;
         2'd2: disp = mt;
         2'd3: disp = mu;
         default: disp = '0;
      endcase
`ifdef TIME_SET_STOPWATCH_EN
      if (state == MODE_SW) begin
         case (sel_nxt)
            2'd2:    disp = sw_tens;
            2'd3:    disp = sw_units;
            default: disp = KEY_BLANK;
         endcase
      end
`endif
   end

   // key is loaded together with sel so the display never sees skew.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         sel      <= '0;
         key      <= '0;
      end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         sel      <= sel_nxt;
         key      <= disp;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

endmodule
